qduc_ctrl: RTL and testbench

QDUC_CTRL -- requirements
Module: qduc_ctrl

---
 rtl/qduc_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_qduc_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qduc_ctrl.sv
// Sample feeder for a quadrature upconverter: buffers I/Q pairs, releases one
// pair every 256 clocks and applies tuning configuration on sample boundaries.
module qduc_ctrl #(
    parameter int ISZ       = 16,
    parameter int FSZ       = 26,
    parameter int DEPTH     = 16,
    parameter int PRIME_LVL = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [ISZ-1:0]   s_i,
    input  logic signed [ISZ-1:0]   s_q,
    input  logic                    cfg_wr,
    input  logic [FSZ-1:0]          cfg_lo_freq,
    input  logic [2:0]              cfg_flags,
    output logic signed [ISZ-1:0]   duc_i,
    output logic signed [ISZ-1:0]   duc_q,
    output logic                    duc_strobe,
    output logic [FSZ-1:0]          lo_freq,
    output logic                    lo_ns_en,
    output logic                    iq_swap,
    output logic                    tuner_byp,
    output logic                    duc_reset,
    output logic                    cfg_pending,
    output logic                    ufl_flag,
    output logic [15:0]             ufl_count,
    input  logic                    ufl_clr,
    output logic [1:0]              state,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
    localparam logic [LW-1:0] START_LVL = LW'(PRIME_LVL);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [2*ISZ-1:0]       mem_r [DEPTH];
    logic [AW-1:0]          wr_ptr_r;
    logic [AW-1:0]          rd_ptr_r;
    logic [LW-1:0]          level_r;
    logic [LW-1:0]          level_nxt_s;
    logic                   s_ready_r;
    logic [1:0]             state_r;
    logic [1:0]             state_nxt_s;
    logic [7:0]             phase_r;
    logic                   duc_reset_r;
    logic signed [ISZ-1:0]  duc_i_r;
    logic signed [ISZ-1:0]  duc_q_r;
    logic                   duc_strobe_r;
    logic [FSZ-1:0]         lo_freq_r;
    logic [2:0]             flags_r;
    logic [FSZ-1:0]         shadow_lo_r;
    logic [2:0]             shadow_flags_r;
    logic                   cfg_pending_r;
    logic                   ufl_flag_r;
    logic [15:0]            ufl_count_r;

    logic                   active_s;
    logic                   slot_s;
    logic                   empty_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   under_s;
    logic                   apply_s;
    logic [2*ISZ-1:0]       rd_word_s;

    // Slot timing, FIFO handshakes and the resulting occupancy.
    always_comb begin
        active_s  = state_r[1];
        slot_s    = active_s && (phase_r == 8'hFF);
        empty_s   = (level_r == {LW{1'b0}});
        push_s    = s_valid && s_ready_r;
        pop_s     = slot_s && !empty_s;
        under_s   = slot_s && empty_s && (state_r == ST_RUN);
        apply_s   = cfg_pending_r && (slot_s || !active_s);
        rd_word_s = mem_r[rd_ptr_r];
        if (push_s && !pop_s) begin
            level_nxt_s = level_r + LW'(1);
        end else if (pop_s && !push_s) begin
            level_nxt_s = level_r - LW'(1);
        end else begin
            level_nxt_s = level_r;
        end
    end

    // Run-state sequencing; an empty slot while draining ends the run.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) state_nxt_s = ST_PRIME;
                else        state_nxt_s = ST_IDLE;
            end
            ST_PRIME: begin
                if (!enable)                    state_nxt_s = ST_IDLE;
                else if (level_r >= START_LVL)  state_nxt_s = ST_RUN;
                else                            state_nxt_s = ST_PRIME;
            end
            ST_RUN: begin
                if (!enable) state_nxt_s = ST_DRAIN;
                else         state_nxt_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (slot_s && empty_s) state_nxt_s = ST_IDLE;
                else if (enable)       state_nxt_s = ST_RUN;
                else                   state_nxt_s = ST_DRAIN;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and the 256-clock phase counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            phase_r     <= 8'd0;
            duc_reset_r <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            phase_r     <= active_s ? (phase_r + 8'd1) : 8'd0;
            duc_reset_r <= !state_nxt_s[1];
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {s_i, s_q};
        end
    end

    // FIFO pointers, occupancy and ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            level_r   <= {LW{1'b0}};
            s_ready_r <= 1'b1;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            level_r   <= level_nxt_s;
            s_ready_r <= (level_nxt_s < FULL_LVL);
        end
    end

    // Sample output: loaded only at slots, zero when nothing was available.
    always_ff @(posedge clk) begin
        if (reset) begin
            duc_i_r      <= '0;
            duc_q_r      <= '0;
            duc_strobe_r <= 1'b0;
        end else begin
            duc_strobe_r <= pop_s || under_s;
            if (pop_s) begin
                duc_i_r <= rd_word_s[2*ISZ-1:ISZ];
                duc_q_r <= rd_word_s[ISZ-1:0];
            end else if (slot_s) begin
                duc_i_r <= '0;
                duc_q_r <= '0;
            end
        end
    end

    // Shadowed tuning config; a same-cycle write re-arms pending for the next slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            lo_freq_r      <= '0;
            flags_r        <= 3'b000;
            shadow_lo_r    <= '0;
            shadow_flags_r <= 3'b000;
            cfg_pending_r  <= 1'b0;
        end else begin
            if (apply_s) begin
                lo_freq_r <= shadow_lo_r;
                flags_r   <= shadow_flags_r;
            end
            if (cfg_wr) begin
                shadow_lo_r    <= cfg_lo_freq;
                shadow_flags_r <= cfg_flags;
                cfg_pending_r  <= 1'b1;
            end else if (apply_s) begin
                cfg_pending_r  <= 1'b0;
            end
        end
    end

    // Underflow bookkeeping; clear wins over a coincident underflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            ufl_flag_r  <= 1'b0;
            ufl_count_r <= 16'd0;
        end else if (ufl_clr) begin
            ufl_flag_r  <= 1'b0;
            ufl_count_r <= 16'd0;
        end else if (under_s) begin
            ufl_flag_r <= 1'b1;
            if (ufl_count_r != 16'hFFFF) begin
                ufl_count_r <= ufl_count_r + 16'd1;
            end
        end
    end

    assign s_ready     = s_ready_r;
    assign duc_i       = duc_i_r;
    assign duc_q       = duc_q_r;
    assign duc_strobe  = duc_strobe_r;
    assign lo_freq     = lo_freq_r;
    assign lo_ns_en    = flags_r[0];
    assign iq_swap     = flags_r[1];
    assign tuner_byp   = flags_r[2];
    assign duc_reset   = duc_reset_r;
    assign cfg_pending = cfg_pending_r;
    assign ufl_flag    = ufl_flag_r;
    assign ufl_count   = ufl_count_r;
    assign state       = state_r;
    assign level       = level_r;

endmodule

// File: tb/tb_qduc_ctrl.sv
// Directed bench for qduc_ctrl: queue-based reference model compared every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_qduc_ctrl;

    localparam int ISZ   = 16;
    localparam int FSZ   = 26;
    localparam int DEPTH = 16;
    localparam int PL    = 8;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  enable = 1'b0;
    logic                  s_valid = 1'b0;
    logic                  s_ready;
    logic signed [ISZ-1:0] s_i = '0;
    logic signed [ISZ-1:0] s_q = '0;
    logic                  cfg_wr = 1'b0;
    logic [FSZ-1:0]        cfg_lo_freq = '0;
    logic [2:0]            cfg_flags = 3'b000;
    logic signed [ISZ-1:0] duc_i;
    logic signed [ISZ-1:0] duc_q;
    logic                  duc_strobe;
    logic [FSZ-1:0]        lo_freq;
    logic                  lo_ns_en;
    logic                  iq_swap;
    logic                  tuner_byp;
    logic                  duc_reset;
    logic                  cfg_pending;
    logic                  ufl_flag;
    logic [15:0]           ufl_count;
    logic                  ufl_clr = 1'b0;
    logic [1:0]            state;
    logic [4:0]            level;

    always #5 clk = ~clk;

    qduc_ctrl #(.ISZ(ISZ), .FSZ(FSZ), .DEPTH(DEPTH), .PRIME_LVL(PL)) dut (
        .clk(clk), .reset(reset), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
        .s_i(s_i), .s_q(s_q), .cfg_wr(cfg_wr), .cfg_lo_freq(cfg_lo_freq), .cfg_flags(cfg_flags),
        .duc_i(duc_i), .duc_q(duc_q), .duc_strobe(duc_strobe), .lo_freq(lo_freq),
        .lo_ns_en(lo_ns_en), .iq_swap(iq_swap), .tuner_byp(tuner_byp), .duc_reset(duc_reset),
        .cfg_pending(cfg_pending), .ufl_flag(ufl_flag), .ufl_count(ufl_count), .ufl_clr(ufl_clr),
        .state(state), .level(level)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // Reference model: samples in a queue, mode 0..3, phase as a plain integer.
    logic [31:0]           m_q [$];
    int                    m_mode = 0;
    int                    m_phase = 0;
    bit                    m_valid = 1'b0;
    logic signed [15:0]    e_i, e_q;
    logic                  e_strobe, e_pend, e_ufl;
    logic [FSZ-1:0]        e_lo, sh_lo;
    logic [2:0]            e_fl, sh_fl;
    int                    e_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err < 60) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    task automatic model_step();
        int lvl;
        bit slot, under, apply;
        logic [31:0] w;
        int nmode;
        if (reset) begin
            m_q.delete();
            m_mode = 0; m_phase = 0;
            e_i = '0; e_q = '0; e_strobe = 1'b0;
            e_lo = '0; e_fl = 3'b000; sh_lo = '0; sh_fl = 3'b000;
            e_pend = 1'b0; e_ufl = 1'b0; e_cnt = 0;
            m_valid = 1'b1;
            return;
        end
        lvl = m_q.size();
        slot = (m_mode >= 2) && (m_phase == 255);
        under = 1'b0;
        nmode = m_mode;
        e_strobe = 1'b0;
        if (slot) begin
            if (lvl > 0) begin
                w = m_q.pop_front();
                e_i = w[31:16]; e_q = w[15:0]; e_strobe = 1'b1;
            end else begin
                e_i = '0; e_q = '0;
                if (m_mode == 2) begin under = 1'b1; e_strobe = 1'b1; end
            end
        end
        apply = e_pend && (m_mode < 2 || slot);
        if (apply) begin e_lo = sh_lo; e_fl = sh_fl; e_pend = 1'b0; end
        if (cfg_wr) begin sh_lo = cfg_lo_freq; sh_fl = cfg_flags; e_pend = 1'b1; end
        if (ufl_clr) begin
            e_ufl = 1'b0; e_cnt = 0;
        end else if (under) begin
            e_ufl = 1'b1;
            if (e_cnt < 65535) e_cnt++;
        end
        case (m_mode)
            0: if (enable) nmode = 1;
            1: if (!enable) nmode = 0; else if (lvl >= PL) nmode = 2;
            2: if (!enable) nmode = 3;
            default: if (slot && lvl == 0) nmode = 0; else if (enable) nmode = 2;
        endcase
        m_phase = (m_mode >= 2) ? (m_phase + 1) % 256 : 0;
        m_mode = nmode;
        if (s_valid && lvl < DEPTH) m_q.push_back({s_i, s_q});
    endtask

    // Model advances on the active edge; outputs are compared on the falling edge.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            cyc++;
            if (m_valid) begin
                chk("state",       32'(state),       32'(m_mode));
                chk("level",       32'(level),       32'(m_q.size()));
                chk("s_ready",     32'(s_ready),     32'(m_q.size() < DEPTH));
                chk("duc_reset",   32'(duc_reset),   32'(m_mode < 2));
                chk("duc_i",       32'(duc_i),       32'(e_i));
                chk("duc_q",       32'(duc_q),       32'(e_q));
                chk("duc_strobe",  32'(duc_strobe),  32'(e_strobe));
                chk("lo_freq",     32'(lo_freq),     32'(e_lo));
                chk("flags",       32'({tuner_byp, iq_swap, lo_ns_en}), 32'(e_fl));
                chk("cfg_pending", 32'(cfg_pending), 32'(e_pend));
                chk("ufl_flag",    32'(ufl_flag),    32'(e_ufl));
                chk("ufl_count",   32'(ufl_count),   32'(e_cnt));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input int q);
        s_valid = 1'b1; s_i = 16'(i); s_q = 16'(q);
        step();
        s_valid = 1'b0;
    endtask

    task automatic wait_strobe(input string name);
        int n;
        n = 0;
        step();
        while (duc_strobe !== 1'b1 && n < 600) begin step(); n++; end
        if (n >= 600) timeout_fail(name);
    endtask

    task automatic wait_phase(input int p);
        int n;
        n = 0;
        while (m_phase != p && n < 600) begin step(); n++; end
        if (n >= 600) timeout_fail("phase wait");
    endtask

    initial begin
        int t_prev, n;
        bit seen;

        // Reset and idle defaults
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst state", 32'(state), 32'd0);
        chk("rst level", 32'(level), 32'd0);
        chk("rst duc_reset", 32'(duc_reset), 32'd1);
        chk("rst s_ready", 32'(s_ready), 32'd1);

        // Config in IDLE: pending for one cycle, then applied
        cfg_lo_freq = 26'h0ABCDEF; cfg_flags = 3'b101; cfg_wr = 1'b1;
        step();
        cfg_wr = 1'b0;
        chk("idle pend", 32'(cfg_pending), 32'd1);
        chk("idle lo before", 32'(lo_freq), 32'd0);
        step();
        chk("idle lo", 32'(lo_freq), 32'h0ABCDEF);
        chk("idle flags", 32'({tuner_byp, iq_swap, lo_ns_en}), 32'd5);
        chk("idle pend clr", 32'(cfg_pending), 32'd0);

        // Prime with 8 samples, run, one strobe per 256 clocks
        enable = 1'b1;
        step();
        chk("prime state", 32'(state), 32'd1);
        for (int k = 1; k <= 8; k++) push(k, -k);
        step();
        chk("run state", 32'(state), 32'd2);
        t_prev = cyc;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                wait_phase(100);
                cfg_lo_freq = 26'h1555555; cfg_flags = 3'b010; cfg_wr = 1'b1;
                step();
                cfg_wr = 1'b0;
                chk("run pend", 32'(cfg_pending), 32'd1);
                chk("run lo held", 32'(lo_freq), 32'h0ABCDEF);
            end
            wait_strobe("strobe");
            chk("gap", 32'(cyc - t_prev), 32'd256);
            t_prev = cyc;
            chk("seq i", 32'(duc_i), 32'(k + 1));
            chk("seq q", 32'(duc_q), 32'(-(k + 1)));
            if (k == 3) begin
                chk("slot lo", 32'(lo_freq), 32'h1555555);
                chk("slot iq_swap", 32'(iq_swap), 32'd1);
                chk("slot pend", 32'(cfg_pending), 32'd0);
            end
        end

        // Three empty slots underflow, then clear
        for (int k = 0; k < 3; k++) begin
            wait_strobe("ufl strobe");
            chk("ufl i", 32'(duc_i), 32'd0);
        end
        chk("ufl count", 32'(ufl_count), 32'd3);
        chk("ufl flag", 32'(ufl_flag), 32'd1);
        ufl_clr = 1'b1;
        step();
        ufl_clr = 1'b0;
        chk("ufl clr count", 32'(ufl_count), 32'd0);
        chk("ufl clr flag", 32'(ufl_flag), 32'd0);

        // Fill to 16 with s_valid held; retry accepted right after the pop
        for (int k = 0; k < 16; k++) begin
            s_valid = 1'b1; s_i = 16'(100 + k); s_q = 16'(k);
            step();
        end
        s_i = 16'(200); s_q = -16'sd200;
        chk("full ready", 32'(s_ready), 32'd0);
        chk("full level", 32'(level), 32'd16);
        repeat (3) step();
        chk("full hold", 32'(level), 32'd16);
        wait_strobe("full strobe");
        chk("full pop i", 32'(duc_i), 32'd100);
        chk("after pop level", 32'(level), 32'd15);
        chk("after pop ready", 32'(s_ready), 32'd1);
        step();
        s_valid = 1'b0;
        chk("refill level", 32'(level), 32'd16);

        // Drain with three queued
        n = 0;
        while (level != 5'd3 && n < 20) begin wait_strobe("pre-drain"); n++; end
        enable = 1'b0;
        step();
        chk("drain state", 32'(state), 32'd3);
        wait_strobe("drain 1");
        chk("drain i1", 32'(duc_i), 32'd114);
        wait_strobe("drain 2");
        chk("drain i2", 32'(duc_i), 32'd115);
        wait_strobe("drain 3");
        chk("drain i3", 32'(duc_i), 32'd200);
        chk("drain q3", 32'(duc_q), 32'hFFFFFF38);
        seen = 1'b0; n = 0;
        while (state != 2'd0 && n < 600) begin
            step(); n++;
            if (duc_strobe) seen = 1'b1;
        end
        chk("drain idle", 32'(state), 32'd0);
        chk("drain no strobe", 32'(seen), 32'd0);
        chk("drain duc_reset", 32'(duc_reset), 32'd1);
        chk("drain ufl", 32'(ufl_count), 32'd0);

        // Config at a slot waits; reset mid-run discards everything
        enable = 1'b1;
        step();
        for (int k = 10; k < 18; k++) push(k, -k);
        step();
        wait_strobe("r2 s1");
        wait_strobe("r2 s2");
        wait_phase(255);
        cfg_lo_freq = 26'h2AAAAAA; cfg_flags = 3'b111; cfg_wr = 1'b1;
        step();
        cfg_wr = 1'b0;
        chk("coinc strobe", 32'(duc_strobe), 32'd1);
        chk("coinc i", 32'(duc_i), 32'd12);
        chk("coinc lo", 32'(lo_freq), 32'h1555555);
        chk("coinc pend", 32'(cfg_pending), 32'd1);
        chk("coinc level", 32'(level), 32'd5);
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid rst state", 32'(state), 32'd0);
        chk("mid rst level", 32'(level), 32'd0);
        chk("mid rst duc_i", 32'(duc_i), 32'd0);
        chk("mid rst duc_q", 32'(duc_q), 32'd0);
        chk("mid rst strobe", 32'(duc_strobe), 32'd0);
        chk("mid rst duc_reset", 32'(duc_reset), 32'd1);
        chk("mid rst lo", 32'(lo_freq), 32'd0);
        chk("mid rst flags", 32'({tuner_byp, iq_swap, lo_ns_en}), 32'd0);
        chk("mid rst pend", 32'(cfg_pending), 32'd0);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
